// File: rtl/reaction_leaderboard.sv
// Reaction-time leaderboard: captures a BCD time on each falling edge of done,
// keeps the four best times sorted ascending, and counts accepted attempts.

module reaction_leaderboard_slot #(
  parameter int IDX = 0
) (
  input  logic        clock50M,
  input  logic        reset,
  input  logic        clear,
  input  logic        insert,
  input  logic [1:0]  pos,
  input  logic [23:0] cand,
  input  logic [23:0] prev_entry,
  input  logic        prev_valid,
  output logic [23:0] entry,
  output logic        valid
);
  localparam logic [1:0] SLOT = IDX[1:0];

  // Slots at or below the insert point take the candidate or their lower neighbour.
  always_ff @(posedge clock50M or posedge reset) begin
    if (reset) begin
      entry <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      entry <= '0;
      valid <= 1'b0;
    end else if (insert) begin
      if (pos == SLOT) begin
        entry <= cand;
        valid <= 1'b1;
      end else if (pos < SLOT) begin
        entry <= prev_entry;
        valid <= prev_valid;
      end
    end
  end
endmodule

module reaction_leaderboard (
  input  logic        clock50M,
  input  logic        reset,
  input  logic        done,
  input  logic [23:0] time_bcd,
  input  logic        clear,
  input  logic [1:0]  rank_sel,
  output logic [23:0] rank_bcd,
  output logic        rank_valid,
  output logic        new_best,
  output logic [7:0]  attempts,
  output logic        busy
);
  localparam int NUM_ENTRIES = 4;

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, INSERT} state_t;

  state_t                             state;
  logic                               done_s1, done_s2, done_q;
  logic                               fall;
  logic [23:0]                        cand;
  logic [2:0]                         pos;
  logic [1:0]                         idx;
  logic                               insert_en;
  logic [NUM_ENTRIES-1:0][23:0]       entry;
  logic [NUM_ENTRIES-1:0]             valid;
  logic [NUM_ENTRIES-1:0][23:0]       prev_entry;
  logic [NUM_ENTRIES-1:0]             prev_valid;

  function automatic logic bcd_ok(input logic [23:0] v);
    for (int d = 0; d < 6; d++)
      if (v[4*d +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  assign fall      = done_q & ~done_s2;
  assign insert_en = (state == INSERT) && !pos[2] && !clear;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign prev_entry[i] = '0;
      assign prev_valid[i] = 1'b0;
    end else begin : g_tail
      assign prev_entry[i] = entry[i-1];
      assign prev_valid[i] = valid[i-1];
    end
    reaction_leaderboard_slot #(.IDX(i)) u_slot (
      .clock50M   (clock50M),
      .reset      (reset),
      .clear      (clear),
      .insert     (insert_en),
      .pos        (pos[1:0]),
      .cand       (cand),
      .prev_entry (prev_entry[i]),
      .prev_valid (prev_valid[i]),
      .entry      (entry[i]),
      .valid      (valid[i])
    );
  end

  always_ff @(posedge clock50M or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      done_s1  <= 1'b0;
      done_s2  <= 1'b0;
      done_q   <= 1'b0;
      cand     <= '0;
      pos      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      attempts <= '0;
      new_best <= 1'b0;
    end else begin
      done_s1 <= done;
      done_s2 <= done_s1;
      done_q  <= done_s2;
      if (clear) begin
        state    <= IDLE;
        cand     <= '0;
        pos      <= '0;
        idx      <= '0;
        busy     <= 1'b0;
        attempts <= '0;
        new_best <= 1'b0;
      end else begin
        case (state)
          IDLE: if (fall) begin
            cand  <= time_bcd;
            busy  <= 1'b1;
            state <= CHECK;
          end
          CHECK: begin
            if (cand == '0 || !bcd_ok(cand)) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              pos   <= '0;
              idx   <= '0;
              state <= SCAN;
            end
          end
          SCAN: begin
            // Ties place the candidate after the existing equal entry.
            if (valid[idx] && entry[idx] <= cand) pos <= {1'b0, idx} + 3'd1;
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= INSERT;
          end
          INSERT: begin
            if (attempts != 8'h99) begin
              if (attempts[3:0] == 4'd9) attempts <= {attempts[7:4] + 4'd1, 4'd0};
              else                       attempts <= attempts + 8'd1;
            end
            new_best <= (pos == 3'd0);
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock50M or posedge reset) begin
    if (reset) begin
      rank_bcd   <= '0;
      rank_valid <= 1'b0;
    end else begin
      rank_bcd   <= valid[rank_sel] ? entry[rank_sel] : '0;
      rank_valid <= valid[rank_sel];
    end
  end
endmodule

// File: tb/tb_reaction_leaderboard.sv
// Scoreboard bench for reaction_leaderboard: a behavioural leaderboard model
// queues expected results per capture; they are checked once the capture retires.

module tb_reaction_leaderboard;
  logic        clock50M = 1'b0;
  logic        reset    = 1'b0;
  logic        done     = 1'b0;
  logic [23:0] time_bcd = '0;
  logic        clear    = 1'b0;
  logic [1:0]  rank_sel = '0;
  logic [23:0] rank_bcd;
  logic        rank_valid;
  logic        new_best;
  logic [7:0]  attempts;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0][23:0] t;
    logic [3:0]       v;
    logic [7:0]       att;
    logic             nb;
    int               busy;
  } exp_t;

  exp_t             sb[$];
  logic [3:0][23:0] m_t;
  logic [3:0]       m_v;
  int               m_n;
  logic             m_nb;

  reaction_leaderboard dut (
    .clock50M   (clock50M),
    .reset      (reset),
    .done       (done),
    .time_bcd   (time_bcd),
    .clear      (clear),
    .rank_sel   (rank_sel),
    .rank_bcd   (rank_bcd),
    .rank_valid (rank_valid),
    .new_best   (new_best),
    .attempts   (attempts),
    .busy       (busy)
  );

  always #10 clock50M = ~clock50M;

  function automatic logic [23:0] to_bcd(input int n);
    logic [23:0] r;
    int k;
    k = n;
    r = '0;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return r;
  endfunction

  function automatic void model_clear();
    m_t  = '0;
    m_v  = '0;
    m_n  = 0;
    m_nb = 1'b0;
  endfunction

  function automatic exp_t model_capture(input logic [23:0] tm);
    exp_t        e;
    logic        ok;
    int          p;
    logic [23:0] a;
    ok = (tm != 24'd0);
    for (int d = 0; d < 6; d++) if (tm[4*d +: 4] > 4'd9) ok = 1'b0;
    if (ok) begin
      p = 0;
      for (int i = 0; i < 4; i++) if (m_v[i] && m_t[i] <= tm) p++;
      if (p < 4) begin
        for (int i = 3; i > p; i--) begin
          m_t[i] = m_t[i-1];
          m_v[i] = m_v[i-1];
        end
        m_t[p] = tm;
        m_v[p] = 1'b1;
      end
      m_n++;
      m_nb = (p == 0);
    end
    a      = to_bcd(m_n > 99 ? 99 : m_n);
    e.t    = m_t;
    e.v    = m_v;
    e.att  = a[7:0];
    e.nb   = m_nb;
    e.busy = ok ? 6 : 1;
    return e;
  endfunction

  // Drives one capture (optionally with a second fall during busy), then scores it.
  task automatic capture(input logic [23:0] tm, input logic [23:0] tm2, input bit dbl, input string tag);
    exp_t e;
    int   bcnt;
    sb.push_back(model_capture(tm));
    time_bcd = tm;
    done     = 1'b1;
    repeat (3) @(negedge clock50M);
    done = 1'b0;
    bcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock50M);
      if (busy) bcnt++;
      if (dbl && c == 1) done = 1'b1;
      if (dbl && c == 3) begin
        done     = 1'b0;
        time_bcd = tm2;
      end
    end
    e = sb.pop_front();
    n_cmp++;
    if (bcnt !== e.busy) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, bcnt, e.busy);
    end
    n_cmp++;
    if (attempts !== e.att) begin
      n_err++;
      $display("FAIL %s attempts: got %h want %h", tag, attempts, e.att);
    end
    n_cmp++;
    if (new_best !== e.nb) begin
      n_err++;
      $display("FAIL %s new_best: got %b want %b", tag, new_best, e.nb);
    end
    for (int r = 0; r < 4; r++) begin
      rank_sel = 2'(r);
      @(negedge clock50M);
      n_cmp++;
      if (rank_valid !== e.v[r] || rank_bcd !== (e.v[r] ? e.t[r] : 24'd0)) begin
        n_err++;
        $display("FAIL %s rank%0d: got %b/%h want %b/%h", tag, r, rank_valid, rank_bcd,
                 e.v[r], e.v[r] ? e.t[r] : 24'd0);
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clock50M);
    clear = 1'b1;
    @(negedge clock50M);
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #4;
    n_cmp++;
    if ({rank_bcd, rank_valid, new_best, attempts, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h/%b/%b/%h/%b want all zero",
               rank_bcd, rank_valid, new_best, attempts, busy);
    end
    @(negedge clock50M);
    reset = 1'b0;
    model_clear();
    rank_sel = 2'd0;
    repeat (3) @(negedge clock50M);
    n_cmp++;
    if (busy !== 1'b0 || rank_valid !== 1'b0 || attempts !== 8'h00) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b valid=%b att=%h want 0/0/00", busy, rank_valid, attempts);
    end
  endtask

  task automatic test_sequence();
    capture(24'h000250, 24'h0, 0, "seq250");
    capture(24'h000180, 24'h0, 0, "seq180");
    capture(24'h000300, 24'h0, 0, "seq300");
    capture(24'h000180, 24'h0, 0, "seq180b");
    capture(24'h000090, 24'h0, 0, "seq090");
    n_cmp++;
    if (attempts !== 8'h05 || new_best !== 1'b1) begin
      n_err++;
      $display("FAIL seq_final: got att=%h nb=%b want 05/1", attempts, new_best);
    end
  endtask

  task automatic test_invalid();
    capture(24'h000000, 24'h0, 0, "inv_zero");
    capture(24'h0000A5, 24'h0, 0, "inv_digit");
  endtask

  task automatic test_full();
    do_clear();
    capture(24'h000100, 24'h0, 0, "full100");
    capture(24'h000200, 24'h0, 0, "full200");
    capture(24'h000300, 24'h0, 0, "full300");
    capture(24'h000400, 24'h0, 0, "full400");
    capture(24'h000500, 24'h0, 0, "full500");
  endtask

  task automatic test_back_to_back();
    capture(24'h000150, 24'h000050, 1, "b2b");
  endtask

  task automatic test_saturate();
    do_clear();
    for (int i = 0; i < 100; i++) begin
      capture(to_bcd(1000 + (i * 37) % 900), 24'h0, 0, "sat");
      if (i == 8) begin
        n_cmp++;
        if (attempts !== 8'h09) begin
          n_err++;
          $display("FAIL sat_09: got %h want 09", attempts);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if (attempts !== 8'h10) begin
          n_err++;
          $display("FAIL sat_carry: got %h want 10", attempts);
        end
      end
    end
    n_cmp++;
    if (attempts !== 8'h99) begin
      n_err++;
      $display("FAIL sat_hold: got %h want 99", attempts);
    end
  endtask

  task automatic test_clear_scan();
    time_bcd = 24'h000005;
    done     = 1'b1;
    repeat (3) @(negedge clock50M);
    done = 1'b0;
    repeat (4) @(negedge clock50M);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL clr_inflight: got busy=%b want 1", busy);
    end
    clear = 1'b1;
    @(negedge clock50M);
    clear = 1'b0;
    model_clear();
    n_cmp++;
    if (busy !== 1'b0 || attempts !== 8'h00 || new_best !== 1'b0) begin
      n_err++;
      $display("FAIL clr_scan: got busy=%b att=%h nb=%b want 0/00/0", busy, attempts, new_best);
    end
    repeat (8) @(negedge clock50M);
    for (int r = 0; r < 4; r++) begin
      rank_sel = 2'(r);
      @(negedge clock50M);
      n_cmp++;
      if (rank_valid !== 1'b0 || rank_bcd !== 24'd0) begin
        n_err++;
        $display("FAIL clr_rank%0d: got %b/%h want 0/000000", r, rank_valid, rank_bcd);
      end
    end
  endtask

  task automatic test_reset_insert();
    capture(24'h000300, 24'h0, 0, "ri300");
    rank_sel = 2'd0;
    time_bcd = 24'h000200;
    done     = 1'b1;
    repeat (3) @(negedge clock50M);
    done = 1'b0;
    repeat (7) @(negedge clock50M);
    n_cmp++;
    if (busy !== 1'b1 || rank_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ri_pre: got busy=%b valid=%b want 1/1", busy, rank_valid);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rank_bcd, rank_valid, new_best, attempts, busy} !== '0) begin
      n_err++;
      $display("FAIL ri_async: got %h/%b/%b/%h/%b want all zero",
               rank_bcd, rank_valid, new_best, attempts, busy);
    end
    @(negedge clock50M);
    reset = 1'b0;
    model_clear();
    repeat (3) @(negedge clock50M);
    for (int r = 0; r < 4; r++) begin
      rank_sel = 2'(r);
      @(negedge clock50M);
      n_cmp++;
      if (rank_valid !== 1'b0 || rank_bcd !== 24'd0) begin
        n_err++;
        $display("FAIL ri_rank%0d: got %b/%h want 0/000000", r, rank_valid, rank_bcd);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequence();
    test_invalid();
    test_full();
    test_back_to_back();
    test_saturate();
    test_clear_scan();
    test_reset_insert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
